// File: rtl/irda_fir_pkg.sv
// Shared definitions for the FIR (4 Mb/s) transmit path: framer state
// encoding, chip-counter width and the fixed IrDA FIR chip patterns.
package irda_fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_STOP     = 3'd4
    } fir_state_t;

    // Chip index within a pattern; 5 bits covers the 32-chip flags.
    localparam int CHIP_CNT_W = 5;

    // Patterns are transmitted leftmost (MSB) chip first.
    localparam logic [15:0] FIR_PREAMBLE   = 16'b1000_0000_1010_1000;
    localparam logic [31:0] FIR_START_FLAG = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
    localparam logic [31:0] FIR_STOP_FLAG  = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

endpackage

// File: rtl/irda_fir_flag_shifter.sv
// Parallel-load chip shifter: holds a pattern of up to 32 chips, presents
// the current chip from the MSB, advances one chip per shift request and
// flags the last chip of the loaded length. Shared by preamble, start flag
// and stop flag so only one pattern register exists in the framer.
module irda_fir_flag_shifter
    import irda_fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  clr,
    input  logic                  load,
    input  logic [31:0]           load_pattern,
    input  logic [CHIP_CNT_W-1:0] load_last,
    input  logic                  shift,
    output logic                  chip,
    output logic                  last
);

    logic [31:0]           pat_reg;
    logic [31:0]           pat_shifted;
    logic [CHIP_CNT_W-1:0] last_idx_reg;
    logic [CHIP_CNT_W-1:0] cnt_reg;

    // One-chip advance: every bit moves toward the MSB, zero fills the LSB.
    assign pat_shifted[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_shift
            assign pat_shifted[gi] = pat_reg[gi-1];
        end
    endgenerate

    // Pattern, length and chip index registers; load beats shift.
    always_ff @(posedge clk) begin
        if (wb_rst_i || clr) begin
            pat_reg      <= '0;
            last_idx_reg <= '0;
            cnt_reg      <= '0;
        end else if (load) begin
            pat_reg      <= load_pattern;
            last_idx_reg <= load_last;
            cnt_reg      <= '0;
        end else if (shift) begin
            pat_reg      <= pat_shifted;
            cnt_reg      <= cnt_reg + 1'b1;
        end
    end

    assign chip = pat_reg[31];
    assign last = (cnt_reg == last_idx_reg);

endmodule

// File: rtl/irda_fir_tx_framer.sv
// FIR transmit framer: wraps the 4PPM chip stream with preamble, start flag
// and stop flag, and sequences the upstream encoder via ppm_restart and
// data_phase. All chip-level activity is paced by fir_tx8_enable.
module irda_fir_tx_framer
    import irda_fir_pkg::*;
#(
    parameter int PREAMBLE_REPS = 16
) (
    input  logic clk,
    input  logic wb_rst_i,
    input  logic fir_tx8_enable,
    input  logic tx_start,
    input  logic tx_abort,
    input  logic data_end,
    input  logic ppm_i,
    output logic fir_tx_o,
    output logic ppm_restart,
    output logic data_phase,
    output logic busy,
    output logic tx_done
);

    localparam logic [3:0]            REP_LAST  = 4'(PREAMBLE_REPS - 1);
    localparam logic [CHIP_CNT_W-1:0] PRE_LAST  = CHIP_CNT_W'(15);
    localparam logic [CHIP_CNT_W-1:0] FLAG_LAST = CHIP_CNT_W'(31);

    fir_state_t state_reg, state_next;
    logic [3:0] rep_reg, rep_next;
    logic [1:0] sym_reg, sym_next;
    logic       stop_sent_reg, stop_sent_next;
    logic       fir_tx_reg, fir_tx_next;
    logic       ppm_restart_reg, ppm_restart_next;
    logic       data_phase_reg, data_phase_next;
    logic       busy_reg, busy_next;
    logic       tx_done_reg, tx_done_next;

    logic                  sh_clr;
    logic                  sh_load;
    logic [31:0]           sh_pattern;
    logic [CHIP_CNT_W-1:0] sh_last_idx;
    logic                  sh_shift;
    logic                  sh_chip;
    logic                  sh_last;

    irda_fir_flag_shifter u_shifter (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .clr          (sh_clr),
        .load         (sh_load),
        .load_pattern (sh_pattern),
        .load_last    (sh_last_idx),
        .shift        (sh_shift),
        .chip         (sh_chip),
        .last         (sh_last)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_reg       <= ST_IDLE;
            rep_reg         <= '0;
            sym_reg         <= '0;
            stop_sent_reg   <= 1'b0;
            fir_tx_reg      <= 1'b0;
            ppm_restart_reg <= 1'b1;
            data_phase_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            tx_done_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rep_reg         <= rep_next;
            sym_reg         <= sym_next;
            stop_sent_reg   <= stop_sent_next;
            fir_tx_reg      <= fir_tx_next;
            ppm_restart_reg <= ppm_restart_next;
            data_phase_reg  <= data_phase_next;
            busy_reg        <= busy_next;
            tx_done_reg     <= tx_done_next;
        end
    end

    // Next-state, next-output and shifter control; abort overrides all.
    always_comb begin
        state_next       = state_reg;
        rep_next         = rep_reg;
        sym_next         = sym_reg;
        stop_sent_next   = stop_sent_reg;
        fir_tx_next      = fir_tx_reg;
        ppm_restart_next = ppm_restart_reg;
        data_phase_next  = data_phase_reg;
        busy_next        = busy_reg;
        tx_done_next     = 1'b0;
        sh_clr           = 1'b0;
        sh_load          = 1'b0;
        sh_pattern       = '0;
        sh_last_idx      = '0;
        sh_shift         = 1'b0;

        if (tx_abort) begin
            state_next       = ST_IDLE;
            rep_next         = '0;
            sym_next         = '0;
            stop_sent_next   = 1'b0;
            fir_tx_next      = 1'b0;
            ppm_restart_next = 1'b1;
            data_phase_next  = 1'b0;
            busy_next        = 1'b0;
            sh_clr           = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tx_start) begin
                        state_next  = ST_PREAMBLE;
                        rep_next    = '0;
                        busy_next   = 1'b1;
                        fir_tx_next = 1'b0;
                        sh_load     = 1'b1;
                        sh_pattern  = {FIR_PREAMBLE, 16'h0000};
                        sh_last_idx = PRE_LAST;
                    end
                end

                ST_PREAMBLE: begin
                    if (fir_tx8_enable) begin
                        fir_tx_next = sh_chip;
                        if (sh_last) begin
                            sh_load = 1'b1;
                            if (rep_reg == REP_LAST) begin
                                // Last repetition done: hand over to the start flag.
                                state_next  = ST_START;
                                rep_next    = '0;
                                sh_pattern  = FIR_START_FLAG;
                                sh_last_idx = FLAG_LAST;
                            end else begin
                                rep_next    = rep_reg + 1'b1;
                                sh_pattern  = {FIR_PREAMBLE, 16'h0000};
                                sh_last_idx = PRE_LAST;
                            end
                        end else begin
                            sh_shift = 1'b1;
                        end
                    end
                end

                ST_START: begin
                    if (fir_tx8_enable) begin
                        fir_tx_next = sh_chip;
                        if (sh_last) begin
                            // Release the encoder on the same edge DATA begins.
                            state_next       = ST_DATA;
                            ppm_restart_next = 1'b0;
                            data_phase_next  = 1'b1;
                            sym_next         = '0;
                            sh_clr           = 1'b1;
                        end else begin
                            sh_shift = 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (fir_tx8_enable) begin
                        fir_tx_next = ppm_i;
                        sym_next    = sym_reg + 1'b1;
                        // Frame may only end on a 4-chip symbol boundary.
                        if (sym_reg == 2'd3 && data_end) begin
                            state_next       = ST_STOP;
                            ppm_restart_next = 1'b1;
                            data_phase_next  = 1'b0;
                            stop_sent_next   = 1'b0;
                            sh_load          = 1'b1;
                            sh_pattern       = FIR_STOP_FLAG;
                            sh_last_idx      = FLAG_LAST;
                        end
                    end
                end

                ST_STOP: begin
                    if (fir_tx8_enable) begin
                        if (stop_sent_reg) begin
                            // One trailing strobe returns the line low and completes.
                            state_next     = ST_IDLE;
                            fir_tx_next    = 1'b0;
                            busy_next      = 1'b0;
                            tx_done_next   = 1'b1;
                            stop_sent_next = 1'b0;
                            sh_clr         = 1'b1;
                        end else begin
                            fir_tx_next = sh_chip;
                            if (sh_last) begin
                                stop_sent_next = 1'b1;
                            end else begin
                                sh_shift = 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_next       = ST_IDLE;
                    fir_tx_next      = 1'b0;
                    ppm_restart_next = 1'b1;
                    data_phase_next  = 1'b0;
                    busy_next        = 1'b0;
                    sh_clr           = 1'b1;
                end
            endcase
        end
    end

    assign fir_tx_o    = fir_tx_reg;
    assign ppm_restart = ppm_restart_reg;
    assign data_phase  = data_phase_reg;
    assign busy        = busy_reg;
    assign tx_done     = tx_done_reg;

endmodule

// File: tb/tb_irda_fir_tx_framer.sv
// Directed bench for irda_fir_tx_framer with a 2-repetition preamble and a
// chip strobe every second clock.
module tb_irda_fir_tx_framer;

    localparam int REPS = 2;

    logic clk = 1'b0;
    logic wb_rst_i = 1'b1;
    logic fir_tx8_enable = 1'b0;
    logic tx_start = 1'b0;
    logic tx_abort = 1'b0;
    logic data_end = 1'b0;
    logic ppm_i = 1'b0;
    logic fir_tx_o, ppm_restart, data_phase, busy, tx_done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;

    logic obs_chip, obs_done, obs_busy;

    logic [15:0] pre_pat   = 16'b1000_0000_1010_1000;
    logic [31:0] start_pat = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
    logic [31:0] stop_pat  = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

    irda_fir_tx_framer #(.PREAMBLE_REPS(REPS)) dut (
        .clk            (clk),
        .wb_rst_i       (wb_rst_i),
        .fir_tx8_enable (fir_tx8_enable),
        .tx_start       (tx_start),
        .tx_abort       (tx_abort),
        .data_end       (data_end),
        .ppm_i          (ppm_i),
        .fir_tx_o       (fir_tx_o),
        .ppm_restart    (ppm_restart),
        .data_phase     (data_phase),
        .busy           (busy),
        .tx_done        (tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe clock followed by one idle clock; outputs captured right
    // after the strobe edge.
    task automatic strobe_once();
        fir_tx8_enable = 1'b1;
        tick();
        obs_chip = fir_tx_o;
        obs_done = tx_done;
        obs_busy = busy;
        fir_tx8_enable = 1'b0;
        strobe_cnt++;
        tick();
    endtask

    task automatic start_frame();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        strobe_cnt = 0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
        vec_cnt++; if (fir_tx_o !== 1'b0) begin err_cnt++; $display("FAIL reset_fir_tx_o got=%b want=0", fir_tx_o); end
        vec_cnt++; if (ppm_restart !== 1'b1) begin err_cnt++; $display("FAIL reset_ppm_restart got=%b want=1", ppm_restart); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b want=0", busy); end
        vec_cnt++; if (data_phase !== 1'b0) begin err_cnt++; $display("FAIL reset_data_phase got=%b want=0", data_phase); end
        vec_cnt++; if (tx_done !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
        $display("test_reset: done");
    endtask

    // Full frame with data 1000_0100 (two symbols); optionally pulses
    // tx_start mid-DATA, which must have no effect.
    task automatic test_frame(input bit inject_start);
        logic [7:0] data_pat;
        int d0;
        logic exp_dp;
        data_pat = 8'b1000_0100;
        d0 = done_cnt;
        start_frame();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL start_busy got=%b want=1", busy); end
        vec_cnt++; if (fir_tx_o !== 1'b0) begin err_cnt++; $display("FAIL start_line_low got=%b want=0", fir_tx_o); end
        for (int i = 0; i < 16 * REPS; i++) begin
            strobe_once();
            vec_cnt++;
            if (obs_chip !== pre_pat[15 - (i % 16)] || ppm_restart !== 1'b1) begin
                err_cnt++;
                $display("FAIL preamble_chip%0d got=%b/%b want=%b/1", i, obs_chip, ppm_restart, pre_pat[15 - (i % 16)]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            strobe_once();
            exp_dp = (i == 31);
            vec_cnt++;
            if (obs_chip !== start_pat[31 - i] || data_phase !== exp_dp || ppm_restart !== !exp_dp) begin
                err_cnt++;
                $display("FAIL startflag_chip%0d got=%b dp=%b rst=%b want=%b dp=%b", i, obs_chip, data_phase, ppm_restart, start_pat[31 - i], exp_dp);
            end
        end
        for (int i = 0; i < 8; i++) begin
            ppm_i = data_pat[7 - i];
            data_end = (i >= 4);
            if (inject_start && i == 2) begin
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
            strobe_once();
            exp_dp = (i != 7);
            vec_cnt++;
            if (obs_chip !== data_pat[7 - i] || data_phase !== exp_dp || ppm_restart !== !exp_dp) begin
                err_cnt++;
                $display("FAIL data_chip%0d got=%b dp=%b rst=%b want=%b dp=%b", i, obs_chip, data_phase, ppm_restart, data_pat[7 - i], exp_dp);
            end
        end
        ppm_i = 1'b0;
        data_end = 1'b0;
        for (int i = 0; i < 32; i++) begin
            strobe_once();
            vec_cnt++;
            if (obs_chip !== stop_pat[31 - i] || obs_done !== 1'b0 || obs_busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL stopflag_chip%0d got=%b done=%b busy=%b want=%b done=0 busy=1", i, obs_chip, obs_done, obs_busy, stop_pat[31 - i]);
            end
        end
        strobe_once();
        vec_cnt++;
        if (obs_chip !== 1'b0 || obs_done !== 1'b1 || obs_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL frame_end got chip=%b done=%b busy=%b want chip=0 done=1 busy=0", obs_chip, obs_done, obs_busy);
        end
        vec_cnt++;
        if (strobe_cnt !== 16 * REPS + 32 + 8 + 32 + 1) begin
            err_cnt++;
            $display("FAIL frame_length got=%0d want=%0d", strobe_cnt, 16 * REPS + 32 + 8 + 32 + 1);
        end
        tick();
        vec_cnt++;
        if (done_cnt - d0 !== 1 || tx_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL done_pulse_count got=%0d level=%b want=1 level=0", done_cnt - d0, tx_done);
        end
        $display("test_frame(inject_start=%0d): %0d strobes", inject_start, strobe_cnt);
    endtask

    // data_end already high on entry to DATA: exactly one symbol is sent.
    task automatic test_min_data();
        logic [3:0] sym_pat;
        sym_pat = 4'b0010;
        start_frame();
        repeat (16 * REPS + 32) strobe_once();
        data_end = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ppm_i = sym_pat[3 - i];
            strobe_once();
            vec_cnt++;
            if (obs_chip !== sym_pat[3 - i] || data_phase !== (i != 3)) begin
                err_cnt++;
                $display("FAIL min_data_chip%0d got=%b dp=%b want=%b dp=%b", i, obs_chip, data_phase, sym_pat[3 - i], (i != 3));
            end
        end
        data_end = 1'b0;
        ppm_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            strobe_once();
            vec_cnt++;
            if (obs_chip !== stop_pat[31 - i]) begin
                err_cnt++;
                $display("FAIL min_stop_chip%0d got=%b want=%b", i, obs_chip, stop_pat[31 - i]);
            end
        end
        strobe_once();
        vec_cnt++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || strobe_cnt !== 16 * REPS + 32 + 4 + 32 + 1) begin
            err_cnt++;
            $display("FAIL min_frame_end got done=%b busy=%b len=%0d want done=1 busy=0 len=%0d", obs_done, obs_busy, strobe_cnt, 16 * REPS + 32 + 4 + 32 + 1);
        end
        $display("test_min_data: %0d strobes", strobe_cnt);
    endtask

    // Abort at start-flag chip 10 together with a strobe, then abort while
    // a preamble '1' chip is on the line.
    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        start_frame();
        repeat (16 * REPS + 10) strobe_once();
        fir_tx8_enable = 1'b1;
        tx_abort = 1'b1;
        tick();
        fir_tx8_enable = 1'b0;
        tx_abort = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || fir_tx_o !== 1'b0 || ppm_restart !== 1'b1 || data_phase !== 1'b0 || tx_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_start got busy=%b chip=%b rst=%b dp=%b done=%b want 0 0 1 0 0", busy, fir_tx_o, ppm_restart, data_phase, tx_done);
        end
        start_frame();
        strobe_once();
        vec_cnt++; if (obs_chip !== 1'b1) begin err_cnt++; $display("FAIL abort_pre_chip0 got=%b want=1", obs_chip); end
        tx_abort = 1'b1;
        tick();
        tx_abort = 1'b0;
        vec_cnt++;
        if (fir_tx_o !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_preamble got chip=%b busy=%b want 0 0", fir_tx_o, busy);
        end
        repeat (10) strobe_once();
        vec_cnt++;
        if (fir_tx_o !== 1'b0 || busy !== 1'b0 || done_cnt !== d0) begin
            err_cnt++;
            $display("FAIL abort_idle_after got chip=%b busy=%b dones=%0d want 0 0 %0d", fir_tx_o, busy, done_cnt, d0);
        end
        $display("test_abort: done");
    endtask

    // tx_start and tx_abort together in IDLE: no frame starts.
    task automatic test_start_with_abort();
        tx_start = 1'b1;
        tx_abort = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_abort = 1'b0;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL start_abort_busy got=%b want=0", busy); end
        repeat (4) strobe_once();
        vec_cnt++;
        if (fir_tx_o !== 1'b0 || busy !== 1'b0 || ppm_restart !== 1'b1) begin
            err_cnt++;
            $display("FAIL start_abort_idle got chip=%b busy=%b rst=%b want 0 0 1", fir_tx_o, busy, ppm_restart);
        end
        $display("test_start_with_abort: done");
    endtask

    initial begin
        test_reset();
        test_frame(1'b0);
        test_min_data();
        test_abort();
        test_start_with_abort();
        test_frame(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
